// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
package uart_pkg;

    // One-hot receiver/transmitter state encoding.
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START     = 5'b00010,
        DATA      = 5'b00100,
        STOP      = 5'b01000,
        WAIT_IDLE = 5'b10000
    } uart_state_e;

    // Clock cycles per line bit (integer floor).
    function automatic int calc_cycles_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Width of a counter that must reach cycles_per_bit-1.
    function automatic int calc_cnt_width(input int cycles_per_bit);
        return (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals entering the i_clk_sys domain.
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             i_clk_sys,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values: simple two-stage shift.
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Synchronizer flops reset to the line's idle level.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver with false-start rejection and framing-error pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | timing to mid start bit; high there means a glitch
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | timing to mid stop bit; high = byte done, low = framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int CYCLES_PER_BIT = calc_cycles_per_bit(CLK_FREQ, BAUD_RATE)
) (
    input  logic       i_clk_sys,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CNT_W = calc_cnt_width(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CYCLES_PER_BIT - 1);

    if (CYCLES_PER_BIT < 16) begin : g_cpb_check
        $error("uart_byte_rx: CYCLES_PER_BIT must be at least 16");
    end

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_d_q, rx_d_d;
    logic             rx_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .i_async   (i_uart_rx),
        .o_sync    (rx_s)
    );

    // Next-state, bit timing and output pulse generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_d_d      = rx_s;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line stuck low never restarts reception.
                if (!rx_s && rx_d_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_byte_d = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_d_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            rx_d_q      <= rx_d_d;
        end
    end

    assign o_rx_byte   = rx_byte_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 50 MHz / 115200 baud.
module tb_uart_byte_rx;

    localparam int CPB = 434;
    localparam int LAT = (19 * CPB) / 2 + 3;   // start edge -> result pulse

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_rx_byte;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_busy;

    uart_byte_rx dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_uart_rx   (rx),
        .o_rx_byte   (o_rx_byte),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         due;
    } ev_t;

    ev_t        exp_q[$];
    int         done_cyc_q[$];
    logic [7:0] model_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drives one 8N1 frame with bit edges at round(k*period) and records the
    // outcome the receiver owes: a byte or a framing error, LAT cycles later.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input real period);
        logic [9:0] bits;
        int t_prev, t_next;
        ev_t ev;
        bits      = {stop_ok, b, 1'b0};
        ev.is_err = !stop_ok;
        ev.data   = b;
        ev.due    = cyc + LAT;
        exp_q.push_back(ev);
        t_prev = 0;
        for (int k = 0; k < 10; k++) begin
            rx     = bits[k];
            t_next = int'((k + 1) * period);
            tick(t_next - t_prev);
            t_prev = t_next;
        end
    endtask

    // Per-cycle compare of DUT outputs against the expected-event model.
    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            model_byte = 8'h00;
            check("reset_outputs", {o_rx_byte, o_rx_done, o_frame_err, o_busy}, 32'h0);
        end else begin
            if (o_rx_done || o_frame_err) begin
                if (o_rx_done) begin
                    n_done++;
                    done_cyc_q.push_back(cyc);
                end
                if (o_frame_err) n_err++;
                check("done_err_exclusive", {31'b0, o_rx_done & o_frame_err}, 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, o_rx_done, o_frame_err}, 32'h0);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", {30'b0, o_rx_done, o_frame_err},
                          ev.is_err ? 32'h1 : 32'h2);
                    check_range("pulse_latency", cyc, ev.due - 2, ev.due + 2);
                    check("busy_at_pulse", {31'b0, o_busy}, ev.is_err ? 32'h1 : 32'h0);
                    if (!ev.is_err) model_byte = ev.data;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 2) begin
                ev = exp_q.pop_front();
                check("missing_pulse", {30'b0, o_rx_done, o_frame_err},
                      ev.is_err ? 32'h1 : 32'h2);
            end
            check("rx_byte_value", {24'b0, o_rx_byte}, {24'b0, model_byte});
        end
    end

    initial begin
        int d0, e0, g0;
        real period;
        logic [9:0] bits;

        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2 * CPB);
        check("idle_busy", {31'b0, o_busy}, 32'h0);

        // Single byte at exact baud.
        d0 = n_done; e0 = n_err;
        send_frame(8'hAB, 1'b1, real'(CPB));
        tick(CPB / 2);
        check("ab_byte", {24'b0, o_rx_byte}, 32'hAB);
        check("ab_done_count", n_done - d0, 1);
        check("ab_err_count", n_err - e0, 0);
        check("ab_busy_after", {31'b0, o_busy}, 32'h0);

        // Four frames back to back, no idle gap.
        d0 = n_done;
        done_cyc_q.delete();
        send_frame(8'hAB, 1'b1, real'(CPB));
        send_frame(8'h41, 1'b1, real'(CPB));
        send_frame(8'h00, 1'b1, real'(CPB));
        send_frame(8'hFF, 1'b1, real'(CPB));
        tick(CPB / 2);
        check("b2b_done_count", n_done - d0, 4);
        check("b2b_last_byte", {24'b0, o_rx_byte}, 32'hFF);
        if (done_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check_range("b2b_spacing", done_cyc_q[i] - done_cyc_q[i-1], 10 * CPB - 2, 10 * CPB + 2);
        end

        // 100-cycle low glitch: rejected at mid start bit.
        d0 = n_done; e0 = n_err;
        g0 = cyc;
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(g0 + 219 - cyc);
        check("glitch_busy_219", {31'b0, o_busy}, 32'h1);
        tick(1);
        check("glitch_idle_220", {31'b0, o_busy}, 32'h0);
        tick(CPB);
        check("glitch_no_done", n_done - d0, 0);
        check("glitch_no_err", n_err - e0, 0);

        // Framing error, long break, then a clean byte.
        d0 = n_done; e0 = n_err;
        send_frame(8'h55, 1'b0, real'(CPB));
        tick(10 * CPB);
        check("break_busy", {31'b0, o_busy}, 32'h1);
        tick(10 * CPB);
        check("fe_err_count", n_err - e0, 1);
        check("fe_no_done", n_done - d0, 0);
        check("fe_byte_kept", {24'b0, o_rx_byte}, 32'hFF);
        rx = 1'b1;
        tick(CPB);
        check("break_end_idle", {31'b0, o_busy}, 32'h0);
        send_frame(8'h3C, 1'b1, real'(CPB));
        tick(CPB / 2);
        check("after_break_byte", {24'b0, o_rx_byte}, 32'h3C);
        check("after_break_done", n_done - d0, 1);

        // Reset in the middle of data bit 4 of 0xC3; the sender aborts too.
        d0 = n_done; e0 = n_err;
        bits = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 5; k++) begin
            rx = bits[k];
            tick(k < 4 ? CPB : CPB / 2);
        end
        check("mid_frame_busy", {31'b0, o_busy}, 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(CPB);
        check("reset_no_pulse", (n_done - d0) + (n_err - e0), 0);
        send_frame(8'h5A, 1'b1, real'(CPB));
        tick(CPB / 2);
        check("post_reset_byte", {24'b0, o_rx_byte}, 32'h5A);

        // Baud mismatch of +3% and -3%.
        e0 = n_err;
        send_frame(8'h96, 1'b1, real'(CPB) / 1.03);
        tick(CPB);
        check("fast_byte", {24'b0, o_rx_byte}, 32'h96);
        send_frame(8'h96, 1'b1, real'(CPB) / 0.97);
        tick(CPB);
        check("slow_byte", {24'b0, o_rx_byte}, 32'h96);
        check("mismatch_no_err", n_err - e0, 0);

        // Random bytes, rates within +/-2%, occasional bad stop bit, short gaps.
        for (int i = 0; i < 4; i++) begin
            bit ok;
            int gap;
            ok     = ($urandom_range(0, 3) != 0);
            period = real'(CPB) * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            send_frame(8'($urandom), ok, period);
            gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            rx  = 1'b1;
            tick(gap * CPB);
        end

        tick(2 * CPB);
        check("events_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Asynchronous serial (8N1) receiver that sits directly upstream of the frame/header receiver.
- Converts the raw `i_uart_rx` line into a byte plus a one-cycle strobe; that strobe feeds the downstream `databyte` / `w_rx_done` inputs.
- Adds a metastability synchronizer, a false-start rejector and framing-error reporting, so the header FSM downstream only ever sees valid bytes.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- CYCLES_PER_BIT, CLK_FREQ/BAUD_RATE (integer floor, 434 at the defaults), clock cycles per bit. Must be >= 16; elaboration error otherwise.

Ports:
- i_clk_sys  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_uart_rx  input  1  raw serial line, asynchronous to i_clk_sys; idles high.
- o_rx_byte  output  8  last correctly received byte; holds its value between strobes.
- o_rx_done  output  1  one-cycle pulse; o_rx_byte is valid in the same cycle.
- o_frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, i_rst=1):
  - o_rx_byte=8'h00, o_rx_done=0, o_frame_err=0, o_busy=0.
  - Synchronizer flops = 1 (idle level), bit counter = 0, cycle counter = 0, state = IDLE.
- Synchronizer: two flops on i_uart_rx, giving rx_s. A third flop, rx_d, holds the previous rx_s for edge detection. Only rx_s is used by the FSM.
- Cycle counter: width $clog2(CYCLES_PER_BIT). It restarts at 0 on every state entry and on every bit boundary.
- IDLE:
  - On rx_s=0 and rx_d=1 (falling edge): go to START, counter cleared.
  - A line held continuously low does not restart reception.
- START:
  - At count = CYCLES_PER_BIT/2 - 1 (mid start bit), sample rx_s.
  - rx_s=1: glitch; return to IDLE with no output pulses.
  - rx_s=0: go to DATA, counter cleared, bit index = 0.
- DATA:
  - Every CYCLES_PER_BIT cycles (mid-bit), shift rx_s into bit 7 of the shift register (LSB-first line order).
  - After the 8th sample (bit index 7): go to STOP.
- STOP:
  - After CYCLES_PER_BIT cycles (mid stop bit), sample rx_s.
  - rx_s=1: on the next cycle, o_rx_byte <= shift register and o_rx_done=1 for exactly one cycle; state returns to IDLE in that same cycle.
  - rx_s=0: o_frame_err=1 for one cycle, o_rx_byte unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers a break condition; no spurious start is detected while the line remains low.
- Latency: o_rx_done asserts 2 synchronizer cycles + 1 register cycle after the mid-stop-bit point of the line waveform.
  - Total from start-bit falling edge ≈ 9.5*CYCLES_PER_BIT + 3 cycles.
- Back-to-back frames: the FSM is in IDLE half a bit before the next start edge, so zero idle time between frames must be received without loss.
- o_rx_done and o_frame_err are never high in the same cycle.
- Reset mid-frame: all state clears immediately; no pulse is produced for the partial byte. After release, the next falling edge starts fresh.
- Sampling tolerance: mid-bit sampling accepts ±3% baud mismatch.

Decomposition:
- Package uart_pkg:
  - State encoding constants: IDLE, START, DATA, STOP, WAIT_IDLE, one-hot 5-bit.
  - Function computing CYCLES_PER_BIT and counter width from CLK_FREQ/BAUD_RATE.
  - Shared with the planned TX block.
- Sub-module sync_2ff (param WIDTH=1, RESET_VAL=1): the two-flop synchronizer, reused wherever async inputs enter i_clk_sys.

Test Plan:
- Send 0xAB at 115200 baud, 50 MHz clock, with a model at exact baud → exactly one o_rx_done pulse with o_rx_byte=8'hAB; o_frame_err stays 0; o_busy falls after the pulse.
- Send 0xAB, 0x41, 0x00, 0xFF back-to-back with no idle gap → four o_rx_done pulses in order with the matching bytes; cycles between pulses = 10*434 ±2.
- Drive a 100-cycle low glitch on an idle line → no o_rx_done, no o_frame_err; state is back in IDLE by cycle 220 after the glitch.
- Send 0x55 with the stop bit forced low → one o_frame_err pulse, no o_rx_done, o_rx_byte keeps its prior value. Hold the line low for 20 bit times, then send 0x3C → only 0x3C is received.
- Assert i_rst for 5 cycles during bit 4 of 0xC3 → no output pulse; the next frame 0x5A is received correctly.
- Send 0x96 with the model running at BAUD_RATE*1.03 and BAUD_RATE*0.97 → o_rx_byte=8'h96 in both cases, no framing error.
